ctrl_slave_rr_arbiter: RTL
==========================

// Module: ctrl_slave_rr_arbiter
// PURPOSE
//  Shares one low-speed Avalon-MM control slave (system ID, config registers) between two
//  masters (m0 = HPS lightweight bridge, m1 = debug/JTAG master). Round-robin arbitration,
//  one transaction in flight at a time, fixed slave read latency. Sits between the
//  interconnect and the slave; the slave sees a single master.
// PARAMETERS
//  ADDR_W        1    slave word-address width
//  DATA_W        32   data width
//  READ_LATENCY  0    slave cycles from s_read to s_readdata valid; legal range 0..7
// PORTS
//  clock            in   1       system clock
//  reset            in   1       asynchronous, active-high reset
//  m0_address       in   ADDR_W  master 0 word address
//  m0_read          in   1       master 0 read request
//  m0_write         in   1       master 0 write request
//  m0_writedata     in   DATA_W  master 0 write data
//  m0_waitrequest   out  1       master 0 stall; low for exactly the accept cycle
//  m0_readdata      out  DATA_W  master 0 read data, valid with m0_readdatavalid
//  m0_readdatavalid out  1       master 0 read-response strobe, 1 cycle
//  m1_*             (same set as m0_*, for master 1)
//  s_address        out  ADDR_W  slave address
//  s_read           out  1       slave read strobe, 1 cycle
//  s_write          out  1       slave write strobe, 1 cycle
//  s_writedata      out  DATA_W  slave write data
//  s_readdata       in   DATA_W  slave read data
// BEHAVIOUR
//  Reset values: mX_waitrequest=1, mX_readdatavalid=0, mX_readdata=0, s_read=0, s_write=0,
//   s_address=0, s_writedata=0, last_grant=1 (so m0 wins the first tie), state=IDLE.
//  FSM: IDLE -> ISSUE -> (write) IDLE | (read) WAIT -> RESP -> IDLE.
//   IDLE : if any mX_read|mX_write, pick winner, latch its address/writedata/rw -> ISSUE.
//   ISSUE: s_read or s_write high one cycle from latched regs; winner's waitrequest=0.
//          Write -> IDLE. Read -> WAIT with lat_cnt=READ_LATENCY.
//   WAIT : lat_cnt decrements; at lat_cnt==0 (incl. READ_LATENCY=0, same edge as leaving
//          ISSUE) register s_readdata into winner's mX_readdata -> RESP.
//   RESP : winner's mX_readdatavalid=1 one cycle; -> IDLE (IDLE may accept next request).
//  Read timing, latency L: request seen at edge of cycle 0; s_read cycle 1; readdatavalid
//   cycle 2+L. Minimum read turnaround 3 cycles (L=0). Write occupies 2 cycles.
//  Arbitration: single requester wins. Both requesting: the master != last_grant wins;
//   last_grant updates on IDLE->ISSUE. Loser keeps waitrequest=1 and is served next.
//  Masters hold command stable while waitrequest=1; a master is never re-granted until its
//   previous read response is delivered (FSM only re-arbitrates from IDLE).
//  mX_read and mX_write both high: treated as read; write ignored.
//  mX_readdata holds its last value between responses; non-winner readdata unchanged.
//  Reset asserted mid-transaction: immediate abort to reset values; no pending
//   readdatavalid is emitted after reset deasserts.
//  lat_cnt width $clog2(READ_LATENCY+1) min 1; no wrap (loads only in ISSUE).
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/ISSUE/WAIT/RESP), grant index constants
//   (GNT_M0=0, GNT_M1=1).
//  Sub-module rr_arbiter_2: combinational req[1:0], last_grant -> gnt_idx, gnt_valid.
//  Top holds FSM, command latches, latency counter, response registers.
// TESTING (slave model: addr0 -> 32'h0000_0000, addr1 -> 32'hCAFE_0001, write stores reg)
//  m0 read addr1, L=0 -> s_read cycle 1, m0_readdatavalid cycle 2, m0_readdata=32'hCAFE_0001.
//  m0,m1 read addr1 same cycle after reset -> m0 served first, m1 valid 3 cycles later;
//   repeat -> m1 served first next round.
//  m1 write 32'h1234_5678 then m0 read -> s_write one cycle, m0 reads 32'h1234_5678.
//  L=3: m0 read -> readdatavalid exactly cycle 5; no s_read re-issue during WAIT.
//  reset pulsed during WAIT -> no readdatavalid afterwards, all outputs at reset values.
//  m0 read and write both high -> only s_read issued, s_write stays 0.

Source files
------------

// File: rtl/ctrl_slave_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_slave_rr_arbiter_pkg
//  Purpose  : Shared FSM state encoding and grant index constants for the
//             two-master control-slave round-robin arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_slave_rr_arbiter_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Grant indices; the grant index doubles as the master select everywhere
    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

endpackage : ctrl_slave_rr_arbiter_pkg
`default_nettype wire

// File: rtl/ctrl_slave_rr_arbiter_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_2
//  Purpose  : Combinational two-way round-robin arbiter. A lone requester
//             wins; on a tie the master that was not granted last wins.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import ctrl_slave_rr_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    // Pick the winner from the request pair and the previous grant
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = GNT_M0;
        case (req)
            2'b01:   gnt_idx = GNT_M0;
            2'b10:   gnt_idx = GNT_M1;
            2'b11:   gnt_idx = ~last_grant;
            default: gnt_idx = GNT_M0;
        endcase
    end

endmodule : rr_arbiter_2
`default_nettype wire

// File: rtl/ctrl_slave_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_slave_rr_arbiter
//  Purpose  : Shares one Avalon-MM control slave between two masters with
//             round-robin arbitration, one transaction in flight, and a fixed
//             slave read latency. All master and slave outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_slave_rr_arbiter
    import ctrl_slave_rr_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 1,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 0
)(
    input  logic              clock,
    input  logic              reset,
    // master 0
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    // master 1
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    // slave
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata
);

    // The counter holds the WAIT cycles still to go after the current one,
    // so ISSUE loads READ_LATENCY-1 and capture happens when it reads zero.
    localparam int LAT_W    = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam int LAT_LOAD = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

    logic [1:0]        req;
    logic              gnt_idx;
    logic              gnt_valid;
    logic [ADDR_W-1:0] win_address;
    logic [DATA_W-1:0] win_writedata;
    logic              win_is_read;

    state_e                  state_q,       state_d;
    logic                    last_grant_q,  last_grant_d;
    logic                    owner_q,       owner_d;
    logic                    is_read_q,     is_read_d;
    logic [LAT_W-1:0]        lat_cnt_q,     lat_cnt_d;
    logic                    s_read_q,      s_read_d;
    logic                    s_write_q,     s_write_d;
    logic [ADDR_W-1:0]       s_address_q,   s_address_d;
    logic [DATA_W-1:0]       s_writedata_q, s_writedata_d;
    logic [1:0]              waitreq_q,     waitreq_d;
    logic [1:0]              rdv_q,         rdv_d;
    logic [1:0][DATA_W-1:0]  rdata_q,       rdata_d;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    rr_arbiter_2 u_rr_arbiter_2 (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    // Select the winning master's command; read takes precedence over write
    always_comb begin
        if (gnt_idx == GNT_M1) begin
            win_address   = m1_address;
            win_writedata = m1_writedata;
            win_is_read   = m1_read;
        end else begin
            win_address   = m0_address;
            win_writedata = m0_writedata;
            win_is_read   = m0_read;
        end
    end

    // Next-state and next-output logic of the transaction sequencer
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        is_read_d     = is_read_q;
        lat_cnt_d     = lat_cnt_q;
        s_address_d   = s_address_q;
        s_writedata_d = s_writedata_q;
        s_read_d      = 1'b0;
        s_write_d     = 1'b0;
        waitreq_d     = 2'b11;
        rdv_d         = 2'b00;
        rdata_d       = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    owner_d            = gnt_idx;
                    last_grant_d       = gnt_idx;
                    is_read_d          = win_is_read;
                    s_address_d        = win_address;
                    s_writedata_d      = win_writedata;
                    s_read_d           = win_is_read;
                    s_write_d          = ~win_is_read;
                    waitreq_d[gnt_idx] = 1'b0;
                    state_d            = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!is_read_q) begin
                    state_d = ST_IDLE;
                end else if (READ_LATENCY == 0) begin
                    // Zero-latency slave: data is valid alongside s_read
                    rdata_d[owner_q] = s_readdata;
                    rdv_d[owner_q]   = 1'b1;
                    state_d          = ST_RESP;
                end else begin
                    lat_cnt_d = LAT_W'(LAT_LOAD);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    rdata_d[owner_q] = s_readdata;
                    rdv_d[owner_q]   = 1'b1;
                    state_d          = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GNT_M1;
            owner_q       <= GNT_M0;
            is_read_q     <= 1'b0;
            lat_cnt_q     <= '0;
            s_read_q      <= 1'b0;
            s_write_q     <= 1'b0;
            s_address_q   <= '0;
            s_writedata_q <= '0;
            waitreq_q     <= 2'b11;
            rdv_q         <= 2'b00;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            is_read_q     <= is_read_d;
            lat_cnt_q     <= lat_cnt_d;
            s_read_q      <= s_read_d;
            s_write_q     <= s_write_d;
            s_address_q   <= s_address_d;
            s_writedata_q <= s_writedata_d;
            waitreq_q     <= waitreq_d;
            rdv_q         <= rdv_d;
            rdata_q       <= rdata_d;
        end
    end

    assign m0_waitrequest   = waitreq_q[GNT_M0];
    assign m0_readdatavalid = rdv_q[GNT_M0];
    assign m0_readdata      = rdata_q[GNT_M0];
    assign m1_waitrequest   = waitreq_q[GNT_M1];
    assign m1_readdatavalid = rdv_q[GNT_M1];
    assign m1_readdata      = rdata_q[GNT_M1];
    assign s_address        = s_address_q;
    assign s_read           = s_read_q;
    assign s_write          = s_write_q;
    assign s_writedata      = s_writedata_q;

endmodule : ctrl_slave_rr_arbiter
`default_nettype wire
